imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the instruction memory: the CPU core only reads it, and this block fills it.
- Takes a byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
- Writes the words to consecutive word addresses, starting at 0. The CPU PC increments by 1 per word, so addresses are word addresses.
- Holds the core stalled (cpu_run low) while loading, then releases it.

Parameters:
ADDR_W, 8, instruction memory word-address width; capacity 2^ADDR_W words
LEN_W, 16, width of the word-count header

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  one-cycle pulse that begins a load session
in_valid  input  1  byte available on in_data
in_data  input  8  stream byte
in_ready  output  1  block accepts a byte this cycle
imem_wr_en  output  1  instruction memory write strobe
imem_wr_addr  output  ADDR_W  word address of the write
imem_wr_data  output  32  word to write
cpu_run  output  1  gates the core clock; 1 = core runs
busy  output  1  load session in progress
overflow  output  1  sticky: header count exceeded capacity
err  output  1  sticky: checksum mismatch (CHECKSUM_EN only; tied 0 otherwise)

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low (rst_n sampled on rising clk); it takes effect regardless of state.
- Reset values:
  - state = IDLE
  - in_ready, imem_wr_en, busy, overflow, err = 0
  - imem_wr_addr = 0, imem_wr_data = 0
  - cpu_run = 0: the core stays halted after reset until a load completes.
- A byte is accepted when in_valid && in_ready. in_ready is combinational from state: 1 in LEN_HI, LEN_LO, DATA and CSUM; 0 otherwise. No backpressure is needed because a memory write takes one cycle.
- States:
  - IDLE: wait for start. On start: busy=1, cpu_run=0, clear overflow/err/counters, go to LEN_HI.
  - LEN_HI: on accept, len[15:8]=byte, go to LEN_LO.
  - LEN_LO: on accept, len[7:0]=byte.
    - len==0: go to CSUM if CHECKSUM_EN, else DONE.
    - len>0: go to DATA.
  - DATA: bytes pack into a shift register; the first byte lands in bits[31:24]. A 2-bit byte counter tracks position.
    - On the 4th byte of a word, the cycle after acceptance shows imem_wr_en=1 for exactly one cycle, imem_wr_data = the assembled word, imem_wr_addr = word index. The index then increments.
    - After word len-1 is accepted, go to CSUM (if enabled) or DONE.
  - DONE: busy=0, cpu_run=1 on the cycle after the final write pulse.
    - start in DONE re-enters LEN_HI and drops cpu_run the next cycle.
    - start while busy is ignored.
- Overflow: if len > 2^ADDR_W, the first 2^ADDR_W words are written. Remaining words are still accepted (the stream is drained) but not written, and overflow is set at the first discarded word. The address never wraps.
- in_valid low between bytes stalls the FSM without losing the partial word.
- Reset mid-session: the partial word is discarded and no write is issued. Words already written remain in memory.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR is kept over all DATA bytes.
  - State CSUM accepts one trailing byte.
  - Match: go to DONE.
  - Mismatch: set err, go to IDLE with cpu_run=0 and busy=0, so the core stays halted.
- Undefined: CSUM state is absent and err is tied 0.

Decomposition:
- Shared package fuzzycpu_pkg:
  - loader state enum (IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE)
  - IMEM_ADDR_W default 8
  - WORD_W = 32
- Sub-module word_packer: byte shift register plus 2-bit byte counter, with a word_valid pulse out. The FSM, address counter and flags stay in imem_loader.

Test Plan:
- Reset → cpu_run=0, busy=0, in_ready=0, imem_wr_en=0; start, then bytes 00 02 11 22 33 44 AA BB CC DD → writes addr0=0x11223344, addr1=0xAABBCCDD; cpu_run=1 one cycle after the 2nd write.
- Same stream with in_valid low for 3 cycles after byte 0x22 → identical writes, only delayed; no spurious imem_wr_en.
- ADDR_W=2, header 00 05, 20 data bytes → 4 writes at addr0..3; 5th word drained, not written; overflow=1; cpu_run=1.
- Header 00 00 → no writes; DONE reached two cycles after the second header byte; cpu_run=1.
- rst_n low after 6 data bytes of a 2-word load → state IDLE next cycle; exactly one write (addr0) occurred; no write for the partial word.
- CHECKSUM_EN: stream 00 01 01 02 04 08, checksum 0x0F → DONE, err=0, cpu_run=1. Checksum 0x0E → err=1, cpu_run=0, state IDLE.

Source files
------------

// File: rtl/fuzzycpu_pkg.sv
// fuzzycpu_pkg: shared types and widths for the instruction memory loader.
package fuzzycpu_pkg;
  localparam int IMEM_ADDR_W = 8;
  localparam int WORD_W = 32;
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE} ld_state_t;
endpackage

// File: rtl/imem_loader_word_packer.sv
// word_packer: packs a byte stream big-endian into 32-bit words, pulsing word_valid on the 4th byte.
module word_packer
  import fuzzycpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [7:0]        in_byte,
  output logic [WORD_W-1:0] word,
  output logic              word_valid
);
  logic [WORD_W-9:0] sr;
  logic [1:0] cnt;
  assign word = {sr, in_byte};
  assign word_valid = en && cnt == 2'd3;
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      sr <= '0;
      cnt <= '0;
    end else if (en) begin
      sr <= word[WORD_W-9:0];
      cnt <= cnt + 2'd1;
    end
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a length-prefixed byte stream into instruction memory and holds the core until done.
// Optional trailing XOR checksum when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader
  import fuzzycpu_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_wr_en,
  output logic [ADDR_W-1:0] imem_wr_addr,
  output logic [WORD_W-1:0] imem_wr_data,
  output logic              cpu_run,
  output logic              busy,
  output logic              overflow,
  output logic              err
);
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam ld_state_t TAIL = CSUM;
  logic [7:0] csum;
`else
  localparam ld_state_t TAIL = DONE;
  assign err = 1'b0;
`endif
  ld_state_t state;
  logic [LEN_W-1:0] len, wcnt, len_nxt;
  logic [WORD_W-1:0] word;
  logic acc, dacc, wv, last, full;
  assign in_ready = state inside {LEN_HI, LEN_LO, DATA, CSUM};
  assign acc = in_valid && in_ready;
  assign dacc = acc && state == DATA;
  assign len_nxt = {len[LEN_W-1:8], in_data};
  assign last = wcnt == len - LEN_W'(1);
  // Words past capacity are drained but never written, so the address cannot wrap.
  assign full = |(wcnt >> ADDR_W);
  word_packer u_pack (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (state != DATA),
    .en         (dacc),
    .in_byte    (in_data),
    .word       (word),
    .word_valid (wv)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      len <= '0;
      wcnt <= '0;
      imem_wr_en <= 1'b0;
      imem_wr_addr <= '0;
      imem_wr_data <= '0;
      cpu_run <= 1'b0;
      busy <= 1'b0;
      overflow <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      err <= 1'b0;
      csum <= '0;
`endif
    end else begin
      imem_wr_en <= wv && !full;
      if (wv && !full) begin
        imem_wr_addr <= wcnt[ADDR_W-1:0];
        imem_wr_data <= word;
      end
      if (wv && full) overflow <= 1'b1;
      if (wv) wcnt <= wcnt + LEN_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (dacc) csum <= csum ^ in_data;
`endif
      case (state)
        IDLE, DONE: begin
          if (state == DONE) begin
            busy <= 1'b0;
            cpu_run <= 1'b1;
          end
          if (start) begin
            state <= LEN_HI;
            busy <= 1'b1;
            cpu_run <= 1'b0;
            overflow <= 1'b0;
            wcnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            err <= 1'b0;
            csum <= '0;
`endif
          end
        end
        LEN_HI: if (acc) begin
          len <= LEN_W'({in_data, 8'h00});
          state <= LEN_LO;
        end
        LEN_LO: if (acc) begin
          len <= len_nxt;
          state <= len_nxt == '0 ? TAIL : DATA;
        end
        DATA: if (wv && last) state <= TAIL;
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM: if (acc) begin
          if (in_data == csum) state <= DONE;
          else begin
            err <= 1'b1;
            busy <= 1'b0;
            cpu_run <= 1'b0;
            state <= IDLE;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven load sessions plus overflow, reset and checksum sequences.
module tb_imem_loader;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif
  logic clk, rst_n, start, in_valid;
  logic [7:0] in_data;
  logic in_ready8, wr_en8, cpu_run8, busy8, ovf8, err8;
  logic [7:0] wr_addr8;
  logic [31:0] wr_data8;
  logic in_ready2, wr_en2, cpu_run2, busy2, ovf2, err2;
  logic [1:0] wr_addr2;
  logic [31:0] wr_data2;
  logic [31:0] mem8 [256];
  logic [31:0] mem2 [4];
  int wr8, wr2, errors, checks;

  imem_loader #(.ADDR_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready8), .imem_wr_en(wr_en8), .imem_wr_addr(wr_addr8), .imem_wr_data(wr_data8),
    .cpu_run(cpu_run8), .busy(busy8), .overflow(ovf8), .err(err8));
  imem_loader #(.ADDR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready2), .imem_wr_en(wr_en2), .imem_wr_addr(wr_addr2), .imem_wr_data(wr_data2),
    .cpu_run(cpu_run2), .busy(busy2), .overflow(ovf2), .err(err2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (wr_en8) begin
      mem8[wr_addr8] = wr_data8;
      wr8++;
    end
    if (wr_en2) begin
      mem2[wr_addr2] = wr_data2;
      wr2++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data = b;
    chk("in_ready", in_ready8, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic begin_session();
    wr8 = 0;
    wr2 = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start cpu_run", cpu_run8, 0);
    chk("start busy", busy8, 1);
  endtask

  typedef struct {
    int n;
    logic [95:0] s;
    int stall;
    int nw;
    logic [63:0] w;
  } vec_t;
  vec_t tv [4];

  initial begin
    logic [7:0] x, b;
    tv[0] = '{10, 96'h0002_1122_3344_AABB_CCDD_0000, -1, 2, 64'h11223344_AABBCCDD};
    tv[1] = '{10, 96'h0002_1122_3344_AABB_CCDD_0000, 3, 2, 64'h11223344_AABBCCDD};
    tv[2] = '{6, 96'h0001_DEAD_BEEF_0000_0000_0000, 4, 1, 64'hDEADBEEF_00000000};
    tv[3] = '{2, 96'h0, -1, 0, 64'h0};
    errors = 0;
    checks = 0;
    wr8 = 0;
    wr2 = 0;
    rst_n = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    tick();
    tick();
    chk("rst cpu_run", cpu_run8, 0);
    chk("rst busy", busy8, 0);
    chk("rst in_ready", in_ready8, 0);
    chk("rst wr_en", wr_en8, 0);
    chk("rst overflow", ovf8, 0);
    chk("rst err", err8, 0);
    chk("rst addr", wr_addr8, 0);
    chk("rst data", wr_data8, 0);
    rst_n = 1'b1;
    tick();
    chk("idle cpu_run", cpu_run8, 0);
    chk("idle in_ready", in_ready8, 0);

    for (int r = 0; r < 4; r++) begin
      mem8[0] = '0;
      mem8[1] = '0;
      begin_session();
      x = 8'h00;
      for (int i = 0; i < tv[r].n; i++) begin
        b = tv[r].s[95-8*i -: 8];
        send(b);
        if (i >= 2) x = x ^ b;
        if (i == tv[r].stall) repeat (3) tick();
      end
      if (CS) send(x);
      chk($sformatf("v%0d final wr_en", r), wr_en8, (tv[r].nw > 0) && !CS);
      chk($sformatf("v%0d final cpu_run", r), cpu_run8, 0);
      chk($sformatf("v%0d final busy", r), busy8, 1);
      tick();
      chk($sformatf("v%0d cpu_run", r), cpu_run8, 1);
      chk($sformatf("v%0d busy", r), busy8, 0);
      chk($sformatf("v%0d overflow", r), ovf8, 0);
      chk($sformatf("v%0d writes", r), wr8, tv[r].nw);
      chk($sformatf("v%0d writes small", r), wr2, tv[r].nw);
      for (int k = 0; k < tv[r].nw; k++)
        chk($sformatf("v%0d word%0d", r, k), mem8[k], tv[r].w[63-32*k -: 32]);
    end

    // Five words into a four-word memory on dut2; dut8 has room for all five.
    begin_session();
    send(8'h00);
    send(8'h05);
    x = 8'h00;
    for (int i = 1; i <= 20; i++) begin
      send(8'(i));
      x = x ^ 8'(i);
    end
    if (CS) send(x);
    tick();
    chk("ovf cpu_run small", cpu_run2, 1);
    chk("ovf cpu_run", cpu_run8, 1);
    chk("ovf flag small", ovf2, 1);
    chk("ovf flag", ovf8, 0);
    chk("ovf writes small", wr2, 4);
    chk("ovf writes", wr8, 5);
    chk("ovf last addr small", wr_addr2, 3);
    for (int k = 0; k < 4; k++)
      chk($sformatf("ovf word%0d", k), mem2[k],
          {8'(4*k+1), 8'(4*k+2), 8'(4*k+3), 8'(4*k+4)});
    chk("ovf word4 big", mem8[4], 32'h11121314);

    // Reset in the middle of the second word.
    mem8[0] = '0;
    begin_session();
    send(8'h00);
    send(8'h02);
    send(8'h11);
    send(8'h22);
    send(8'h33);
    send(8'h44);
    send(8'hAA);
    send(8'hBB);
    rst_n = 1'b0;
    tick();
    chk("midrst busy", busy8, 0);
    chk("midrst in_ready", in_ready8, 0);
    chk("midrst cpu_run", cpu_run8, 0);
    chk("midrst wr_en", wr_en8, 0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("midrst writes", wr8, 1);
    chk("midrst word0", mem8[0], 32'h11223344);
    chk("midrst idle", in_ready8, 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    begin_session();
    send(8'h00);
    send(8'h01);
    send(8'h01);
    send(8'h02);
    send(8'h04);
    send(8'h08);
    send(8'h0F);
    chk("csum ok err", err8, 0);
    tick();
    chk("csum ok cpu_run", cpu_run8, 1);
    begin_session();
    send(8'h00);
    send(8'h01);
    send(8'h01);
    send(8'h02);
    send(8'h04);
    send(8'h08);
    send(8'h0E);
    chk("csum bad err", err8, 1);
    chk("csum bad busy", busy8, 0);
    chk("csum bad in_ready", in_ready8, 0);
    chk("csum bad cpu_run", cpu_run8, 0);
    tick();
    chk("csum bad halted", cpu_run8, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
